// File: rtl/dsd_pkg.sv
// dsd_pkg: shared state encoding and parity-mode constants for the serial link
package dsd_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    PAR  = 2'd2,
    DONE = 2'd3
  } par_state_t;
  localparam logic EVEN_PARITY     = 1'b0;
  localparam logic ODD_PARITY_MODE = 1'b1;
endpackage

// File: rtl/parity_accum.sv
// parity_accum: registered running XOR with synchronous clear and enable
module parity_accum (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic d,
  output logic q
);
  logic nxt;
  xor_gate u_xor (.a(q), .b(d), .y(nxt));
  // clear wins over enable so an aborting start never folds in a discarded bit
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= 1'b0;
    else if (clr) q <= 1'b0;
    else if (en) q <= nxt;
endmodule

// File: rtl/xor_gate.sv
// xor_gate: two-input combinational XOR primitive
module xor_gate (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a ^ b;
endmodule

// File: rtl/serial_parity_checker.sv
// serial_parity_checker: deserialises DATA_W LSB-first bits and checks a trailing parity bit
module serial_parity_checker
  import dsd_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic              busy,
  output logic [DATA_W-1:0] data_out,
  output logic              frame_valid,
  output logic              parity_err
);
  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);
  localparam logic PMODE = ODD_PARITY ? ODD_PARITY_MODE : EVEN_PARITY;
  par_state_t state;
  logic [CW-1:0] cnt;
  logic [DATA_W-1:0] shift;
  logic acc;
  parity_accum u_acc (
    .clk(clk),
    .rst_n(rst_n),
    .clr(start),
    .en(bit_valid && state == RECV && !start),
    .d(bit_in),
    .q(acc)
  );
  // frame FSM; start from any state restarts reception, outputs are registered
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      shift       <= '0;
      busy        <= 1'b0;
      data_out    <= '0;
      frame_valid <= 1'b0;
      parity_err  <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      if (start) begin
        state <= RECV;
        busy  <= 1'b1;
        cnt   <= '0;
        shift <= '0;
      end else begin
        case (state)
          RECV: if (bit_valid) begin
            shift[cnt] <= bit_in;
            cnt        <= cnt == LAST ? '0 : cnt + 1'b1;
            state      <= cnt == LAST ? PAR : RECV;
          end
          PAR: if (bit_valid) begin
            state       <= DONE;
            busy        <= 1'b0;
            frame_valid <= 1'b1;
            data_out    <= shift;
            parity_err  <= acc ^ bit_in ^ PMODE;
          end
          DONE: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
endmodule

// File: doc/serial_parity_checker.md
Name: serial_parity_checker

Overview:
- Serial-input frame receiver that sits downstream of the xor_gate primitive. It accumulates a running XOR (parity) over DATA_W serial data bits, then compares the result against a trailing received parity bit.
- Presents the deserialised word together with a parity-error flag for one cycle per frame.
- Intended as the parity stage of the team's serial link (UART-style receive path).

Parameters:
- DATA_W, 8, number of data bits per frame (legal range 2..32).
- ODD_PARITY, 0, 0 = even parity expected, 1 = odd parity expected.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse that begins a new frame.
- bit_in  input  1  serial data/parity bit; sampled only when bit_valid=1.
- bit_valid  input  1  qualifies bit_in for this cycle.
- busy  output  1  high while a frame is being received (RECV or PAR).
- data_out  output  DATA_W  deserialised word; bit i = i-th data bit received (LSB first).
- frame_valid  output  1  one-cycle pulse; data_out and parity_err are valid in that cycle.
- parity_err  output  1  1 = received parity bit mismatches the computed parity.

Behaviour:
- Reset (rst_n=0, async): state=IDLE; busy, frame_valid, parity_err = 0; data_out, shift register, bit counter and parity accumulator = 0.
- FSM states: IDLE, RECV, PAR, DONE.
- IDLE:
  - start=1 -> RECV; clear the counter, accumulator and shift register.
  - bit_valid is ignored in IDLE.
- RECV, on each cycle with bit_valid=1:
  - acc <= acc ^ bit_in.
  - shift[cnt] <= bit_in.
  - cnt <= cnt+1.
  - When the DATA_W-th bit is accepted (cnt = DATA_W-1), move to PAR in the next cycle.
  - bit_valid=0 holds state; there is no timeout.
- PAR:
  - The next bit_valid=1 cycle supplies the parity bit p.
  - err = acc ^ p ^ ODD_PARITY. For even parity, err=1 when the popcount of data plus p is odd.
  - Go to DONE.
- DONE: lasts exactly one cycle.
  - frame_valid=1; data_out=shift; parity_err=err.
  - Then IDLE.
- Output register rules:
  - data_out and parity_err are registered.
  - They hold their last frame value until the next DONE; they are not cleared when frame_valid falls.
- busy=1 in RECV and PAR only. It is 0 in IDLE and DONE.
- Latency: frame_valid rises in the cycle after the clock edge that accepts the parity bit (one register stage).
- start while busy (RECV/PAR):
  - The current frame is aborted: counter, accumulator and shift register are cleared; state=RECV.
  - No frame_valid is emitted for the aborted frame.
  - start and bit_valid in the same cycle: the bit is discarded and start has priority.
- start in DONE: DONE still emits its pulse, then the FSM enters RECV directly (start is captured), not IDLE.
- Back-to-back frames: start may assert in the cycle immediately after DONE; no idle gap is required.
- Reset mid-frame: immediate return to the reset state; no frame_valid.
- Counter width: $clog2(DATA_W); it wraps only via the state transition, never arithmetically.

Decomposition:
- Shared package dsd_pkg:
  - State enum type par_state_t (IDLE=2'd0, RECV=2'd1, PAR=2'd2, DONE=2'd3).
  - Constants EVEN_PARITY=0 and ODD_PARITY_MODE=1.
- One natural sub-module: parity_accum.
  - A 1-bit registered XOR accumulator with clear and enable, built on xor_gate.
  - Lets the combinational xor_gate primitive be reused directly.
- The FSM, counter and shift register stay in the top module.

Test Plan:
- Even parity, DATA_W=8:
  - Stimulus: start, then bits of 0xA5 LSB first (1,0,1,0,0,1,0,1), then parity 0.
  - Required: frame_valid one cycle, data_out=8'hA5, parity_err=0, busy=0 afterwards.
- Even parity error: same frame with parity bit 1 -> data_out=8'hA5, parity_err=1.
- ODD_PARITY=1:
  - Frame 0x07 with parity 0 -> parity_err=0.
  - Same frame with parity 1 -> parity_err=1.
- Gapped input: 0x3C sent with bit_valid toggling every other cycle -> data_out=8'h3C; frame_valid only after the 9th valid bit.
- Abort:
  - Send 5 bits, pulse start, then send the full 0xFF frame with parity 0.
  - Required: exactly one frame_valid, data_out=8'hFF, parity_err=0.
- Reset mid-frame:
  - Drop rst_n after 4 bits -> all outputs 0 immediately (asynchronous).
  - After release, a 0x01 frame with parity 1 -> data_out=8'h01, parity_err=0.
